fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the instruction ROM.
- Holds the program counter and drives the ROM address. Captures the combinational ROM read data into a 2-entry prefetch queue.
- Presents {pc, instruction} to decode with a valid/ready handshake.
- Accepts redirects (branch/jump/exception) from later stages and discards all queued wrong-path instructions.

---
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit: instruction fetch stage sitting directly in front of the ROM.
//   Holds the word-addressed PC, drives the ROM address, captures the
//   combinational ROM data into a 2-entry prefetch queue and presents the
//   queue head {pc, inst} to decode over a valid/ready handshake. A redirect
//   from a later stage reloads the PC and flushes every queued entry.
//
// Ports:
//   clk           core clock, rising edge
//   rst           asynchronous active-high reset
//   rom_addr_o    ROM word address (current pc)
//   rom_data_i    ROM read data, combinational from rom_addr_o
//   redirect_i    load redirect_pc_i into pc and flush the queue
//   redirect_pc_i redirect target
//   valid_o       queue head valid
//   ready_i       decode accepts the head this cycle
//   inst_o/pc_o   head instruction and its address (0 when empty)
//   fetch_cnt_o   (FETCH_PERF_EN only) number of instructions handed to decode
//   stall_cnt_o   (FETCH_PERF_EN only) cycles with no handshake-ready head
//
// Build option: define FETCH_PERF_EN to add the two performance counters.
// -----------------------------------------------------------------------------

package pico;
  localparam int unsigned A      = 6;
  localparam int unsigned W_INST = 32;
endpackage

module fetch_unit #(
  parameter int unsigned A        = pico::A,
  parameter int unsigned W_INST   = pico::W_INST,
  parameter logic [A-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [A-1:0]      rom_addr_o,
  input  logic [W_INST-1:0] rom_data_i,
  input  logic              redirect_i,
  input  logic [A-1:0]      redirect_pc_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [W_INST-1:0] inst_o,
`ifdef FETCH_PERF_EN
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       stall_cnt_o,
`endif
  output logic [A-1:0]      pc_o
);

  localparam int unsigned W_CNT = 2;

  logic [A-1:0]      pc_q, pc_d;
  logic [W_CNT-1:0]  count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [A-1:0]      ent_pc_q   [2];
  logic [W_INST-1:0] ent_inst_q [2];

  logic head_valid;
  logic pop;
  logic push;

  // Handshake decode; redirect suppresses both queue operations.
  assign head_valid = (count_q != W_CNT'(0));
  assign pop        = head_valid & ready_i & ~redirect_i;
  // A full queue can still take a new entry when the head leaves this cycle.
  assign push       = ~redirect_i & ((count_q != W_CNT'(2)) | pop);

  // Next-state for pc, occupancy and pointers.
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_i) begin
      pc_d     = redirect_pc_i;
      count_d  = W_CNT'(0);
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        pc_d     = pc_q + A'(1);
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + W_CNT'(1);
        2'b01:   count_d = count_q - W_CNT'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      count_q  <= W_CNT'(0);
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Queue storage: write {pc, rom data} at the write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_pc_q[0]   <= '0;
      ent_pc_q[1]   <= '0;
      ent_inst_q[0] <= '0;
      ent_inst_q[1] <= '0;
    end else if (push) begin
      ent_pc_q[wr_ptr_q]   <= pc_q;
      ent_inst_q[wr_ptr_q] <= rom_data_i;
    end
  end

  // Outputs are decoded from flops; stale entries are masked to zero.
  assign rom_addr_o = pc_q;
  assign valid_o    = head_valid;
  assign inst_o     = head_valid ? ent_inst_q[rd_ptr_q] : '0;
  assign pc_o       = head_valid ? ent_pc_q[rd_ptr_q]   : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (pop) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (!head_valid || !ready_i) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit: self-checking bench for fetch_unit (A=6, W_INST=32,
// rom[i] = 32'hA000_0000 + i). A cycle table checks the visible outputs every
// cycle; a scoreboard of expected pc values checks every handshake.
// -----------------------------------------------------------------------------

module tb_fetch_unit;

  localparam int unsigned A = 6;
  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect_i = 1'b0;
  logic [A-1:0]  redirect_pc_i = '0;
  logic          ready_i = 1'b0;
  logic [A-1:0]  rom_addr_o;
  logic [W-1:0]  rom_data_i;
  logic          valid_o;
  logic [W-1:0]  inst_o;
  logic [A-1:0]  pc_o;
`ifdef FETCH_PERF_EN
  logic [31:0]   fetch_cnt_o;
  logic [31:0]   stall_cnt_o;
`endif

  fetch_unit #(.A(A), .W_INST(W), .RESET_PC(6'd0)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_addr_o   (rom_addr_o),
    .rom_data_i   (rom_data_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .inst_o       (inst_o),
`ifdef FETCH_PERF_EN
    .fetch_cnt_o  (fetch_cnt_o),
    .stall_cnt_o  (stall_cnt_o),
`endif
    .pc_o         (pc_o)
  );

  always #5 clk = ~clk;

  // Combinational ROM.
  assign rom_data_i = 32'hA000_0000 + 32'(rom_addr_o);

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: pc values decode should receive, in order.
  logic [A-1:0] exp_q[$];
  logic [A-1:0] sb_e;

  task automatic sb_restart(input logic [A-1:0] start);
    logic [A-1:0] p;
    p = start;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(p);
      p = p + 6'd1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid_o && ready_i && !redirect_i) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_pc", 32'(pc_o), 32'(sb_e));
        chk("sb_inst", inst_o, 32'hA000_0000 + 32'(sb_e));
      end
    end
  end

  // Per-cycle vector: inputs for the cycle and outputs expected in it.
  typedef struct {
    logic         rst;
    logic         ready;
    logic         redir;
    logic [A-1:0] rpc;
    logic         ev;
    logic [A-1:0] epc;
    logic [A-1:0] eaddr;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic r, input logic rdy, input logic rd, input logic [A-1:0] rpc,
                   input logic ev, input logic [A-1:0] epc, input logic [A-1:0] eaddr);
    vec_t t;
    t.rst = r; t.ready = rdy; t.redir = rd; t.rpc = rpc;
    t.ev = ev; t.epc = epc; t.eaddr = eaddr;
    tbl.push_back(t);
  endtask

  initial begin
    int pops;
    logic [A-1:0] held_addr;

    // Streaming, redirects, wrap, back-to-back redirects.
    v(1, 1, 0, 6'h00, 0, 6'h00, 6'h00);
    v(0, 1, 0, 6'h00, 0, 6'h00, 6'h00);
    v(0, 1, 0, 6'h00, 1, 6'h00, 6'h01);
    v(0, 1, 0, 6'h00, 1, 6'h01, 6'h02);
    v(0, 1, 0, 6'h00, 1, 6'h02, 6'h03);
    v(0, 1, 0, 6'h00, 1, 6'h03, 6'h04);
    v(0, 1, 0, 6'h00, 1, 6'h04, 6'h05);
    v(0, 1, 1, 6'h20, 1, 6'h05, 6'h06);
    v(0, 1, 0, 6'h00, 0, 6'h00, 6'h20);
    v(0, 1, 1, 6'h3F, 1, 6'h20, 6'h21);
    v(0, 1, 0, 6'h00, 0, 6'h00, 6'h3F);
    v(0, 1, 0, 6'h00, 1, 6'h3F, 6'h00);
    v(0, 1, 0, 6'h00, 1, 6'h00, 6'h01);
    v(0, 1, 1, 6'h10, 1, 6'h01, 6'h02);
    v(0, 1, 1, 6'h30, 0, 6'h00, 6'h10);
    v(0, 1, 0, 6'h00, 0, 6'h00, 6'h30);
    v(0, 1, 0, 6'h00, 1, 6'h30, 6'h31);
    v(0, 1, 0, 6'h00, 1, 6'h31, 6'h32);
    // Decode stall: queue fills, pc freezes at 3, head held at 1.
    v(1, 1, 0, 6'h00, 0, 6'h00, 6'h00);
    v(0, 1, 0, 6'h00, 0, 6'h00, 6'h00);
    v(0, 1, 0, 6'h00, 1, 6'h00, 6'h01);
    v(0, 0, 0, 6'h00, 1, 6'h01, 6'h02);
    v(0, 0, 0, 6'h00, 1, 6'h01, 6'h03);
    v(0, 0, 0, 6'h00, 1, 6'h01, 6'h03);
    v(0, 0, 0, 6'h00, 1, 6'h01, 6'h03);
    v(0, 1, 0, 6'h00, 1, 6'h01, 6'h03);
    v(0, 1, 0, 6'h00, 1, 6'h02, 6'h04);
    v(0, 1, 0, 6'h00, 1, 6'h03, 6'h05);
    v(0, 1, 0, 6'h00, 1, 6'h04, 6'h06);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst           = tbl[i].rst;
      ready_i       = tbl[i].ready;
      redirect_i    = tbl[i].redir;
      redirect_pc_i = tbl[i].rpc;
      if (tbl[i].rst) sb_restart(6'h00);
      else if (tbl[i].redir) sb_restart(tbl[i].rpc);
      @(negedge clk);
      chk($sformatf("row%0d_valid", i), 32'(valid_o), 32'(tbl[i].ev));
      chk($sformatf("row%0d_pc", i), 32'(pc_o), 32'(tbl[i].epc));
      chk($sformatf("row%0d_inst", i), inst_o,
          tbl[i].ev ? 32'hA000_0000 + 32'(tbl[i].epc) : 32'd0);
      chk($sformatf("row%0d_addr", i), 32'(rom_addr_o), 32'(tbl[i].eaddr));
    end

    // Fill the queue, confirm pc is frozen, then reset mid-cycle.
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
    ready_i    = 1'b0;
    @(negedge clk);
    held_addr = rom_addr_o;
    @(posedge clk);
    #1;
    chk("full_valid", 32'(valid_o), 32'd1);
    chk("full_addr_frozen", 32'(rom_addr_o), 32'(held_addr));
    #1;
    rst = 1'b1;
    sb_restart(6'h00);
    #1;
    chk("async_rst_valid", 32'(valid_o), 32'd0);
    chk("async_rst_addr", 32'(rom_addr_o), 32'd0);
    chk("async_rst_pc", 32'(pc_o), 32'd0);
    chk("async_rst_inst", inst_o, 32'd0);
`ifdef FETCH_PERF_EN
    chk("async_rst_fetch_cnt", fetch_cnt_o, 32'd0);
    chk("async_rst_stall_cnt", stall_cnt_o, 32'd0);
`endif

    // Ten handshakes with decode stalled for three cycles.
    @(posedge clk);
    #1;
    rst  = 1'b0;
    pops = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc != 0) begin
        @(posedge clk);
        #1;
      end
      ready_i = (cyc >= 3 && cyc <= 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (valid_o && ready_i) pops++;
      if (pops == 10) break;
    end
    chk("perf_pops", 32'(pops), 32'd10);
    @(posedge clk);
    #1;
`ifdef FETCH_PERF_EN
    chk("fetch_cnt", fetch_cnt_o, 32'd10);
    chk("stall_cnt", stall_cnt_o, 32'd4);
`endif
    chk("sb_remaining", 32'(exp_q.size()), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
